// File: rtl/mem_stage_pkg.sv
// Shared bus layouts and response-FSM encoding for the MEM pipeline stage.
// Packed structs list fields MSB first, so each struct matches its flat bus bit-for-bit.
package mem_stage_pkg;

  localparam int EXE_TO_MEM_BUS_WD = 80;
  localparam int MEM_TO_WB_BUS_WD  = 111;
  localparam int MEM_TO_BY_BUS_WD  = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic [2:0]  vstage;
    logic        rf_w_en;
    logic        sel_rf_w_data;
    logic        sel_data_ram_wd;
    logic [3:0]  b_en;
    logic        mem_rd;
    logic [4:0]  w_addr;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } exe_mem_t;

  typedef struct packed {
    logic [2:0]  vstage;
    logic        rf_w_en;
    logic        sel_rf_w_data;
    logic        sel_data_ram_wd;
    logic [3:0]  b_en;
    logic [31:0] ram_rdata;
    logic [4:0]  w_addr;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } mem_wb_t;

  typedef struct packed {
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        fwd_valid;
    logic        mem_valid;
    logic        rf_w_en;
  } mem_by_t;

  // Register 0 always reads as zero, so it never forwards a non-zero value.
  function automatic logic [31:0] bypass_data(input logic [4:0] w_addr, input logic sel_rf,
                                              input logic [31:0] ram_rdata,
                                              input logic [31:0] alu_result);
    if (w_addr == 5'd0) return 32'h0;
    return sel_rf ? ram_rdata : alu_result;
  endfunction

endpackage

// File: rtl/mem_resp_buf.sv
// Tracks the data-RAM read response for the instruction held in MEM and buffers it
// while WB stalls; passes a same-cycle response straight through otherwise.
module mem_resp_buf
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        mem_rd,
  input  logic        accept,
  input  logic        new_mem_rd,
  input  logic        leave,
  input  logic        data_ok,
  input  logic [31:0] r_data,
  output logic        ready_go,
  output logic [31:0] rdata
);

  resp_state_e state;
  logic [31:0] rdata_buf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      // NOTE: the buffer is a single register rather than a RAM, so it is cleared with the FSM.
      rdata_buf <= 32'h0;
    end else if (accept) begin
      state <= new_mem_rd ? ST_WAIT : ST_IDLE;
    end else if (leave) begin
      state <= ST_IDLE;
    end else if (state == ST_WAIT && data_ok) begin
      state     <= ST_HOLD;
      rdata_buf <= r_data;
    end
  end

  assign ready_go = ~mem_rd | (state == ST_WAIT && data_ok) | (state == ST_HOLD);
  assign rdata    = ~mem_rd ? 32'h0 : (state == ST_HOLD) ? rdata_buf : r_data;

  // A response is only legal while a load is waiting for it.
  assert property (@(posedge clk) disable iff (reset) data_ok |-> (valid && state == ST_WAIT));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EXE/MEM instruction, merges the data-RAM read word into
// the WB payload and publishes bypass information for the register-file forwarding network.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  input  logic                         EXE_to_MEM_valid,
  output logic                         MEM_allow_in,
  input  logic                         data_ram_data_ok,
  input  logic [31:0]                  data_ram_r_data,
  output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
  output logic                         MEM_to_WB_valid,
  input  logic                         WB_allow_in,
  output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus
);

  exe_mem_t    payload;
  exe_mem_t    incoming;
  logic        mem_valid;
  logic        ready_go;
  logic        accept;
  logic        leave;
  logic [31:0] ram_rdata;
  mem_wb_t     wb;
  mem_by_t     by;

  assign incoming        = exe_mem_t'(EXE_to_MEM_bus);
  assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
  assign MEM_to_WB_valid = mem_valid & ready_go;
  assign accept          = EXE_to_MEM_valid & MEM_allow_in;
  assign leave           = MEM_to_WB_valid & WB_allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments so every register samples values from before the edge.
      mem_valid <= 1'b0;
      payload   <= '0;
    end else begin
      if (MEM_allow_in) mem_valid <= EXE_to_MEM_valid;
      if (accept)       payload   <= incoming;
    end
  end

  mem_resp_buf u_resp_buf (
    .clk        (clk),
    .reset      (reset),
    .valid      (mem_valid),
    .mem_rd     (payload.mem_rd),
    .accept     (accept),
    .new_mem_rd (incoming.mem_rd),
    .leave      (leave),
    .data_ok    (data_ram_data_ok),
    .r_data     (data_ram_r_data),
    .ready_go   (ready_go),
    .rdata      (ram_rdata)
  );

  always_comb begin
    wb = '{vstage:          payload.vstage,
           rf_w_en:         payload.rf_w_en,
           sel_rf_w_data:   payload.sel_rf_w_data,
           sel_data_ram_wd: payload.sel_data_ram_wd,
           b_en:            payload.b_en,
           ram_rdata:       ram_rdata,
           w_addr:          payload.w_addr,
           alu_result:      payload.alu_result,
           pc:              payload.pc};
    // Loads seen only by vstage[2] forward from WB instead of here.
    by = '{w_addr:    payload.w_addr,
           w_data:    bypass_data(payload.w_addr, payload.sel_rf_w_data, ram_rdata,
                                  payload.alu_result),
           fwd_valid: MEM_to_WB_valid & (payload.vstage[0] | payload.vstage[1]),
           mem_valid: mem_valid,
           rf_w_en:   payload.rf_w_en};
  end

  assign MEM_to_WB_bus = wb;
  assign MEM_to_BY_bus = by;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cycle table, hand-written stall/reset
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [79:0]  in_bus;
  logic         in_valid;
  logic         allow_in;
  logic         data_ok;
  logic [31:0]  r_data;
  logic [110:0] wb_bus;
  logic         wb_valid;
  logic         wb_allow;
  logic [39:0]  by_bus;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .EXE_to_MEM_bus   (in_bus),
    .EXE_to_MEM_valid (in_valid),
    .MEM_allow_in     (allow_in),
    .data_ram_data_ok (data_ok),
    .data_ram_r_data  (r_data),
    .MEM_to_WB_bus    (wb_bus),
    .MEM_to_WB_valid  (wb_valid),
    .WB_allow_in      (wb_allow),
    .MEM_to_BY_bus    (by_bus)
  );

  // Bus layouts written out independently of the design package.
  function automatic logic [79:0] mk(input logic [2:0] vs, input logic rfw, input logic sel_rf,
                                     input logic sel_wd, input logic [3:0] ben, input logic mrd,
                                     input logic [4:0] wa, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {vs, rfw, sel_rf, sel_wd, ben, mrd, wa, alu, pc};
  endfunction

  function automatic logic [110:0] wb_of(input logic [79:0] i, input logic [31:0] rd);
    return {i[79:70], (i[69] ? rd : 32'h0), i[68:0]};
  endfunction

  function automatic logic [39:0] by_of(input logic [79:0] i, input logic [31:0] rd);
    logic [31:0] r;
    logic [31:0] wd;
    r  = i[69] ? rd : 32'h0;
    wd = (i[68:64] == 5'd0) ? 32'h0 : (i[75] ? r : i[63:32]);
    return {i[68:64], wd, i[77] | i[78], 1'b1, i[76]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [79:0] i, input logic wa, input logic ok,
                     input logic [31:0] rd);
    @(negedge clk);
    in_valid = v;
    in_bus   = i;
    wb_allow = wa;
    data_ok  = ok;
    r_data   = rd;
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic ea,
                           input logic [79:0] ei, input logic [31:0] erd);
    check({tag, " wb_valid"}, 128'(wb_valid), 128'(ev));
    check({tag, " allow_in"}, 128'(allow_in), 128'(ea));
    if (ev) begin
      check({tag, " wb_bus"}, 128'(wb_bus), 128'(wb_of(ei, erd)));
      check({tag, " by_bus"}, 128'(by_bus), 128'(by_of(ei, erd)));
    end else begin
      check({tag, " fwd_valid"}, 128'(by_bus[2]), 128'(0));
    end
  endtask

  typedef struct {
    logic        in_valid;
    logic [79:0] instr;
    logic        wb_allow;
    logic        data_ok;
    logic [31:0] rdata;
    logic        exp_valid;
    logic        exp_allow;
    logic [79:0] exp_instr;
    logic [31:0] exp_rd;
    logic        exp_fwd;
  } vec_t;

  function automatic vec_t mkv(input logic v, input logic [79:0] i, input logic wa,
                               input logic ok, input logic [31:0] rd, input logic ev,
                               input logic ea, input logic [79:0] ei, input logic [31:0] erd,
                               input logic ef);
    vec_t t;
    t = '{v, i, wa, ok, rd, ev, ea, ei, erd, ef};
    return t;
  endfunction

  vec_t vecs[$];

  logic [79:0] i1, l1, i5, l2, la, lb, ic, l3, l6, ix;
  logic        m_held, m_got;
  logic [79:0] m_instr;
  logic [31:0] m_data;

  initial begin
    i1 = mk(3'b001, 1'b1, 1'b0, 1'b0, 4'hf, 1'b0, 5'd3, 32'h5,        32'h1c000000);
    l1 = mk(3'b001, 1'b1, 1'b1, 1'b0, 4'hf, 1'b1, 5'd4, 32'h100,      32'h1c000004);
    i5 = mk(3'b001, 1'b1, 1'b0, 1'b0, 4'hf, 1'b0, 5'd0, 32'h7,        32'h1c000008);
    l2 = mk(3'b100, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 5'd5, 32'h104,      32'h1c00000c);
    la = mk(3'b011, 1'b1, 1'b1, 1'b0, 4'hf, 1'b1, 5'd7, 32'h200,      32'h1c000010);
    lb = mk(3'b010, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 5'd8, 32'h204,      32'h1c000014);
    ic = mk(3'b001, 1'b1, 1'b0, 1'b0, 4'hf, 1'b0, 5'd9, 32'h1234abcd, 32'h1c000018);
    l3 = mk(3'b010, 1'b1, 1'b1, 1'b0, 4'hf, 1'b1, 5'd6, 32'h300,      32'h1c000020);
    l6 = mk(3'b001, 1'b1, 1'b1, 1'b0, 4'hf, 1'b1, 5'd2, 32'h400,      32'h1c000024);
    ix = mk(3'b001, 1'b1, 1'b0, 1'b0, 4'hf, 1'b0, 5'd1, 32'h99,       32'h1c000028);

    // ALU pass, load waiting two cycles, w_addr=0 bypass, vstage[2]-only load, back-to-back.
    vecs.push_back(mkv(1, i1, 1, 0, 0,            0, 1, 0,  0,            0));
    vecs.push_back(mkv(0, 0,  1, 0, 0,            1, 1, i1, 0,            1));
    vecs.push_back(mkv(1, l1, 1, 0, 0,            0, 1, 0,  0,            0));
    vecs.push_back(mkv(0, 0,  1, 0, 32'h55,       0, 0, 0,  0,            0));
    vecs.push_back(mkv(0, 0,  1, 1, 32'hdeadbeef, 1, 1, l1, 32'hdeadbeef, 1));
    vecs.push_back(mkv(1, i5, 1, 0, 0,            0, 1, 0,  0,            0));
    vecs.push_back(mkv(0, 0,  1, 0, 0,            1, 1, i5, 0,            1));
    vecs.push_back(mkv(1, l2, 1, 0, 0,            0, 1, 0,  0,            0));
    vecs.push_back(mkv(0, 0,  1, 1, 32'hcafe0001, 1, 1, l2, 32'hcafe0001, 0));
    vecs.push_back(mkv(1, la, 1, 0, 0,            0, 1, 0,  0,            0));
    vecs.push_back(mkv(1, lb, 1, 1, 32'ha1a1a1a1, 1, 1, la, 32'ha1a1a1a1, 1));
    vecs.push_back(mkv(1, ic, 1, 1, 32'hb2b2b2b2, 1, 1, lb, 32'hb2b2b2b2, 1));
    vecs.push_back(mkv(0, 0,  1, 0, 0,            1, 1, ic, 0,            1));

    reset = 1'b1;
    in_valid = 1'b0; in_bus = '0; wb_allow = 1'b0; data_ok = 1'b0; r_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset wb_valid", 128'(wb_valid), 128'(0));
    check("reset allow_in", 128'(allow_in), 128'(1));
    check("reset fwd_valid", 128'(by_bus[2]), 128'(0));

    foreach (vecs[k]) begin
      cyc(vecs[k].in_valid, vecs[k].instr, vecs[k].wb_allow, vecs[k].data_ok, vecs[k].rdata);
      check_out($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_allow,
                vecs[k].exp_instr, vecs[k].exp_rd);
      check($sformatf("vec%0d fwd", k), 128'(by_bus[2]), 128'(vecs[k].exp_fwd));
    end

    // Response arrives while WB stalls for three cycles; buffered word must survive.
    cyc(1, l3, 1, 0, 0);
    check_out("hold accept", 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'h12345678);
    check_out("hold ok", 1, 0, l3, 32'h12345678);
    cyc(0, 0, 0, 0, 32'hffffffff);
    check_out("hold stall1", 1, 0, l3, 32'h12345678);
    cyc(0, 0, 0, 0, 32'hffffffff);
    check_out("hold stall2", 1, 0, l3, 32'h12345678);
    cyc(0, 0, 1, 0, 32'hffffffff);
    check_out("hold release", 1, 1, l3, 32'h12345678);
    cyc(0, 0, 1, 0, 0);
    check_out("hold empty", 0, 1, 0, 0);

    // Reset while waiting; the RAM is in reset too, so its stray response coincides with it.
    cyc(1, l6, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_out("rst wait", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1; data_ok = 1'b1; r_data = 32'hbad0bad0;
    @(negedge clk);
    reset = 1'b0; data_ok = 1'b0; r_data = 32'h0;
    #1;
    check_out("rst after", 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_out("rst idle", 0, 1, 0, 0);
    cyc(1, ix, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_out("rst alu", 1, 1, ix, 0);

    // Randomized traffic against a model of "one held instruction, its response if any".
    m_held = 1'b0; m_got = 1'b0; m_instr = '0; m_data = '0;
    for (int c = 0; c < 600; c++) begin
      logic        v, wa, ok, rdy, ea;
      logic [79:0] ni;
      logic [31:0] rd, erd;
      ni = mk(3'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()), 4'($urandom()),
              1'($urandom()), 5'($urandom()), $urandom(), $urandom());
      v  = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 3) != 0);
      ok = m_held && m_instr[69] && !m_got && ($urandom_range(0, 1) == 1);
      rd = $urandom();
      cyc(v, ni, wa, ok, rd);
      rdy = m_held && (!m_instr[69] || m_got || ok);
      erd = m_got ? m_data : rd;
      ea  = !m_held || (rdy && wa);
      check_out($sformatf("rand%0d", c), rdy, ea, m_instr, erd);
      if (rdy && wa) begin
        m_held = 1'b0;
        m_got  = 1'b0;
      end else if (ok) begin
        m_got  = 1'b1;
        m_data = rd;
      end
      if (ea && v) begin
        m_held  = 1'b1;
        m_instr = ni;
        m_got   = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
